inv: RTL and testbench

// - 1-bit half subtractor (x - y) with a combinational difference/borrow path.
// - Adds a registered copy of the result and a saturating borrow-event counter for downstream monitoring.
// - Leaf arithmetic cell, used standalone or as the LSB stage of wider subtractors.

---
 rtl/inv.sv | 56 +++++
 tb/tb_inv.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/inv.sv
// 1-bit half subtractor (x - y) with a registered copy of the result and a
// saturating counter of enabled borrow cycles for downstream monitoring.
module inv #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             x,
    input  logic             y,
    output logic             d,
    output logic             b,
    output logic             d_q,
    output logic             b_q,
    output logic             vld,
    output logic [CNT_W-1:0] borrow_cnt,
    output logic             cnt_sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    assign d = x ^ y;
    assign b = ~x & y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= 1'b0;
            b_q <= 1'b0;
            vld <= 1'b0;
        end else begin
            if (en) begin
                d_q <= d;
                b_q <= b;
            end
            vld <= en;
        end
    end

    // en is tested first so an unknown x/y cannot reach the counter while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            borrow_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (clr) begin
            borrow_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (en && b && (borrow_cnt != CNT_MAX)) begin
            borrow_cnt <= borrow_cnt + CNT_W'(1);
            if (borrow_cnt == CNT_MAX - CNT_W'(1)) begin
                cnt_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inv.sv
// Self-checking bench for inv: a default-width instance and a 2-bit counter
// instance share stimulus and are compared against an integer reference model.
module tb_inv;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic x = 1'b0;
    logic y = 1'b0;

    logic       d8, b8, dq8, bq8, vld8, sat8;
    logic [7:0] cnt8;
    logic       d2, b2, dq2, bq2, vld2, sat2;
    logic [1:0] cnt2;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    // reference model state
    bit m_dq, m_bq, m_vld;
    int m_cnt8, m_cnt2;

    always #5 clk = ~clk;

    inv #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .y(y),
        .d(d8), .b(b8), .d_q(dq8), .b_q(bq8), .vld(vld8),
        .borrow_cnt(cnt8), .cnt_sat(sat8)
    );

    inv #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .x(x), .y(y),
        .d(d2), .b(b2), .d_q(dq2), .b_q(bq2), .vld(vld2),
        .borrow_cnt(cnt2), .cnt_sat(sat2)
    );

    // Model: subtraction as plain integer arithmetic, counters as clamped integers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dq   <= 1'b0;
            m_bq   <= 1'b0;
            m_vld  <= 1'b0;
            m_cnt8 <= 0;
            m_cnt2 <= 0;
        end else begin
            if (en) begin
                m_dq <= ((int'(x) - int'(y)) & 1) != 0;
                m_bq <= (int'(x) - int'(y)) < 0;
            end
            m_vld <= en;
            if (clr) begin
                m_cnt8 <= 0;
                m_cnt2 <= 0;
            end else if (en && (int'(x) < int'(y))) begin
                m_cnt8 <= (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
                m_cnt2 <= (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
            end
        end
    end

    task automatic drive(input bit e, input bit c, input bit xv, input bit yv);
        @(negedge clk);
        en  = e;
        clr = c;
        x   = xv;
        y   = yv;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        chk_cnt++;
        if ({dq8, bq8, vld8, cnt8, sat8} !== 12'h000) $display("FAIL reset8 got %b expected 0", {dq8, bq8, vld8, cnt8, sat8});
        else pass_cnt++;
        chk_cnt++;
        if ({dq2, bq2, vld2, cnt2, sat2} !== 6'h00) $display("FAIL reset2 got %b expected 0", {dq2, bq2, vld2, cnt2, sat2});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released at %0t", $time);
    endtask

    task automatic test_truth_table();
        bit [1:0] exp_db [4];
        exp_db[0] = 2'b00; exp_db[1] = 2'b11; exp_db[2] = 2'b10; exp_db[3] = 2'b00;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            {x, y} = 2'(i);
            #1;
            chk_cnt++;
            if ({d8, b8} !== exp_db[i]) $display("FAIL truth x,y=%b got d,b=%b expected %b", 2'(i), {d8, b8}, exp_db[i]);
            else pass_cnt++;
            chk_cnt++;
            if ({d2, b2} !== exp_db[i]) $display("FAIL truth2 x,y=%b got d,b=%b expected %b", 2'(i), {d2, b2}, exp_db[i]);
            else pass_cnt++;
            $display("truth x,y=%b d,b=%b", 2'(i), {d8, b8});
        end
    endtask

    task automatic test_registered();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        edge_settle();
        chk_cnt++;
        if ({dq8, bq8, vld8} !== 3'b111) $display("FAIL reg_capture got d_q,b_q,vld=%b expected 111", {dq8, bq8, vld8});
        else pass_cnt++;
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        edge_settle();
        chk_cnt++;
        if ({dq8, bq8, vld8} !== 3'b110) $display("FAIL reg_hold got d_q,b_q,vld=%b expected 110", {dq8, bq8, vld8});
        else pass_cnt++;
        $display("registered capture/hold d_q,b_q,vld=%b", {dq8, bq8, vld8});
    endtask

    task automatic test_counting();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, (i >= 3), 1'b1);
        edge_settle();
        chk_cnt++;
        if (cnt8 !== 8'd3) $display("FAIL count got %0d expected 3", cnt8);
        else pass_cnt++;
        chk_cnt++;
        if (sat8 !== 1'b0) $display("FAIL count_sat got %b expected 0", sat8);
        else pass_cnt++;
        $display("counting borrow_cnt=%0d", cnt8);
    endtask

    task automatic test_saturation();
        int exp_cnt [5];
        bit exp_sat [5];
        exp_cnt = '{1, 2, 3, 3, 3};
        exp_sat = '{0, 0, 1, 1, 1};
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        edge_settle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b1);
            edge_settle();
            chk_cnt++;
            if (int'(cnt2) !== exp_cnt[i] || sat2 !== exp_sat[i])
                $display("FAIL sat cycle %0d got cnt=%0d sat=%b expected cnt=%0d sat=%b", i + 1, cnt2, sat2, exp_cnt[i], exp_sat[i]);
            else pass_cnt++;
            $display("saturation cycle %0d cnt=%0d sat=%b", i + 1, cnt2, sat2);
        end
    endtask

    task automatic test_clear_priority();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        edge_settle();
        chk_cnt++;
        if (cnt2 !== 2'd0 || sat2 !== 1'b0) $display("FAIL clr_prio got cnt=%0d sat=%b expected 0/0", cnt2, sat2);
        else pass_cnt++;
        chk_cnt++;
        if (cnt8 !== 8'd0) $display("FAIL clr_prio8 got cnt=%0d expected 0", cnt8);
        else pass_cnt++;
        chk_cnt++;
        if (vld8 !== 1'b1) $display("FAIL clr_vld got vld=%b expected 1", vld8);
        else pass_cnt++;
        $display("clear priority cnt=%0d sat=%b", cnt2, sat2);
    endtask

    task automatic test_async_reset();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
        edge_settle();
        chk_cnt++;
        if (cnt8 !== 8'd5) $display("FAIL pre_reset got cnt=%0d expected 5", cnt8);
        else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({dq8, bq8, vld8, cnt8, sat8} !== 12'h000) $display("FAIL async_reset got %b expected 0", {dq8, bq8, vld8, cnt8, sat8});
        else pass_cnt++;
        $display("async reset mid-count cnt=%0d vld=%b", cnt8, vld8);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int ed, eb;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                  1'($urandom), 1'($urandom));
            #1;
            ed = ((int'(x) - int'(y)) & 1);
            eb = (int'(x) < int'(y)) ? 1 : 0;
            chk_cnt++;
            if (int'(d8) !== ed || int'(b8) !== eb) $display("FAIL rand_comb %0d got d,b=%b%b expected %0d%0d", n, d8, b8, ed, eb);
            else pass_cnt++;
            edge_settle();
            chk_cnt++;
            if (dq8 !== m_dq || bq8 !== m_bq || vld8 !== m_vld ||
                dq2 !== m_dq || bq2 !== m_bq || vld2 !== m_vld)
                $display("FAIL rand_reg %0d got %b%b%b expected %b%b%b", n, dq8, bq8, vld8, m_dq, m_bq, m_vld);
            else pass_cnt++;
            chk_cnt++;
            if (int'(cnt8) !== m_cnt8 || sat8 !== (m_cnt8 == 255) ||
                int'(cnt2) !== m_cnt2 || sat2 !== (m_cnt2 == 3))
                $display("FAIL rand_cnt %0d got %0d/%b %0d/%b expected %0d %0d", n, cnt8, sat8, cnt2, sat2, m_cnt8, m_cnt2);
            else pass_cnt++;
            $display("rand %0d en=%b clr=%b x=%b y=%b cnt8=%0d cnt2=%0d sat2=%b", n, en, clr, x, y, cnt8, cnt2, sat2);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_registered();
        test_counting();
        test_saturation();
        test_clear_priority();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
